// File: rtl/adder_pkg.sv
// Shared types for the digit-serial adder: controller state encoding.
package adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; master supplies operands and takes results.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/add_digit.sv
// DIGIT-bit combinational ripple adder; also exposes the carry into its top bit for overflow.
module add_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);
    logic [DIGIT:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout    = c[DIGIT];
    assign msb_cin = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: accepts a, b, cin, then adds DIGIT bits per cycle over WIDTH/DIGIT cycles.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    logic [31:0]      off;
    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_c, dig_msb_cin;
    logic             last, accept;

    assign off    = 32'(cnt_q) * 32'(DIGIT);
    assign dig_a  = a_q[off +: DIGIT];
    assign dig_b  = b_q[off +: DIGIT];
    assign last   = (cnt_q == CW'(N - 1));

    add_digit #(.DIGIT(DIGIT)) u_add_digit (
        .a       (dig_a),
        .b       (dig_b),
        .cin     (carry_q),
        .sum     (dig_s),
        .cout    (dig_c),
        .msb_cin (dig_msb_cin)
    );

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                sum_d[off +: DIGIT] = dig_s;
                carry_d = dig_c;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    // The last digit holds the word MSB, so its top-bit carries define ovf.
                    state_d = DONE;
                    cout_d  = dig_c;
                    ovf_d   = dig_msb_cin ^ dig_c;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Accept overrides the DONE->IDLE return, giving back-to-back operation.
        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: four WIDTH=8 adders (DIGIT 1,2,4,8) against an arithmetic reference.
module tb_serial_adder;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]      iv, ordy, icin;
    logic [NI-1:0][7:0] ia, ib;
    wire  [NI-1:0]      ir, ov, co, of, bz;
    wire  [NI-1:0][7:0] sm;

    int checks = 0;
    int failures = 0;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            serial_adder_if #(.WIDTH(8)) bus ();
            logic bsy;
            assign bus.in_valid  = iv[g];
            assign bus.a         = ia[g];
            assign bus.b         = ib[g];
            assign bus.cin       = icin[g];
            assign bus.out_ready = ordy[g];
            serial_adder #(.WIDTH(8), .DIGIT(1 << g)) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (bus.in_valid),
                .in_ready  (bus.in_ready),
                .a         (bus.a),
                .b         (bus.b),
                .cin       (bus.cin),
                .out_valid (bus.out_valid),
                .out_ready (bus.out_ready),
                .sum       (bus.sum),
                .cout      (bus.cout),
                .ovf       (bus.ovf),
                .busy      (bsy)
            );
            assign ir[g] = bus.in_ready;
            assign ov[g] = bus.out_valid;
            assign sm[g] = bus.sum;
            assign co[g] = bus.cout;
            assign of[g] = bus.ovf;
            assign bz[g] = bsy;
        end
    endgenerate

    // Reference: {ovf, cout, sum} from plain integer addition and sign rules.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'd0, c};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t[8], t[7:0]};
    endfunction

    function automatic int n_of(input int k);
        return 8 / (1 << k);
    endfunction

    task automatic accept(input int k, input logic [7:0] x, input logic [7:0] y, input logic c);
        iv[k] = 1'b1; ia[k] = x; ib[k] = y; icin[k] = c;
        @(posedge clk); @(negedge clk);
        iv[k] = 1'b0; ia[k] = 8'($urandom); ib[k] = 8'($urandom); icin[k] = 1'($urandom);
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (ov[k]) begin lat = c; break; end
        end
    endtask

    task automatic consume(input int k);
        ordy[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({ov[k], bz[k], co[k], of[k], sm[k]} !== 12'h000) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: got ov=%b busy=%b cout=%b ovf=%b sum=%h, want all 0",
                         k, ov[k], bz[k], co[k], of[k], sm[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (ir[k] !== 1'b1) begin
                failures++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]);
            end
        end
    endtask

    task automatic run_check(input string nm, input int k, input logic [7:0] x, input logic [7:0] y,
                             input logic c);
        int lat;
        logic [9:0] e;
        e = ref_add(x, y, c);
        checks++;
        if (ir[k] !== 1'b1) begin
            failures++; $display("FAIL %s_ready[%0d]: got %b want 1", nm, k, ir[k]);
        end
        accept(k, x, y, c);
        wait_done(k, lat);
        checks++;
        if (lat !== n_of(k)) begin
            failures++; $display("FAIL %s_latency[%0d]: got %0d want %0d", nm, k, lat, n_of(k));
        end
        checks++;
        if ({of[k], co[k], sm[k]} !== e) begin
            failures++;
            $display("FAIL %s_result[%0d]: a=%h b=%h cin=%b got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     nm, k, x, y, c, of[k], co[k], sm[k], e[9], e[8], e[7:0]);
        end
        consume(k);
        checks++;
        if (ov[k] !== 1'b0 || bz[k] !== 1'b0) begin
            failures++; $display("FAIL %s_release[%0d]: got ov=%b busy=%b want 0 0", nm, k, ov[k], bz[k]);
        end
    endtask

    task automatic test_directed;
        run_check("ff_plus_1", 0, 8'hFF, 8'h01, 1'b0);
        run_check("7f_plus_1", 0, 8'h7F, 8'h01, 1'b0);
        run_check("80_plus_80", 0, 8'h80, 8'h80, 1'b0);
        run_check("digit4", 2, 8'h3C, 8'h0A, 1'b1);
        run_check("digit8_single", 3, 8'hC8, 8'h9C, 1'b1);
        run_check("digit2_carry", 1, 8'hAA, 8'h55, 1'b1);
    endtask

    task automatic test_hold_back_to_back;
        int lat;
        logic [9:0] e1, e2;
        for (int k = 0; k < NI; k++) begin
            e1 = ref_add(8'h5A, 8'h33, 1'b1);
            e2 = ref_add(8'hC1, 8'hE7, 1'b0);
            accept(k, 8'h5A, 8'h33, 1'b1);
            wait_done(k, lat);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); @(negedge clk);
                checks++;
                if ({ov[k], of[k], co[k], sm[k]} !== {1'b1, e1}) begin
                    failures++;
                    $display("FAIL hold[%0d] cyc %0d: got ov=%b ovf=%b cout=%b sum=%h want 1 %b %b %h",
                             k, i, ov[k], of[k], co[k], sm[k], e1[9], e1[8], e1[7:0]);
                end
            end
            ordy[k] = 1'b1;
            #1;
            checks++;
            if (ir[k] !== 1'b1) begin
                failures++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, ir[k]);
            end
            accept(k, 8'hC1, 8'hE7, 1'b0);
            ordy[k] = 1'b0;
            checks++;
            if (bz[k] !== 1'b1 || ov[k] !== 1'b0) begin
                failures++; $display("FAIL b2b_state[%0d]: got busy=%b ov=%b want 1 0", k, bz[k], ov[k]);
            end
            wait_done(k, lat);
            checks++;
            if (lat !== n_of(k) || {of[k], co[k], sm[k]} !== e2) begin
                failures++;
                $display("FAIL b2b_result[%0d]: got lat=%0d ovf=%b cout=%b sum=%h want lat=%0d %b %b %h",
                         k, lat, of[k], co[k], sm[k], n_of(k), e2[9], e2[8], e2[7:0]);
            end
            consume(k);
        end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        accept(0, 8'hFF, 8'hFF, 1'b1);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov[0], bz[0], co[0], of[0], sm[0]} !== 12'h000) begin
            failures++;
            $display("FAIL midrun_reset: got ov=%b busy=%b cout=%b ovf=%b sum=%h want all 0",
                     ov[0], bz[0], co[0], of[0], sm[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            failures++; $display("FAIL midrun_ready: got %b want 1", ir[0]);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (ov[0] || bz[0]) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL midrun_no_pulse: got %0d active cycles want 0", seen);
        end
        run_check("after_reset", 0, 8'h12, 8'h34, 1'b0);
    endtask

    task automatic test_random;
        int lat;
        logic [7:0] x, y;
        logic c;
        logic [9:0] e;
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 250; n++) begin
                x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
                e = ref_add(x, y, c);
                accept(k, x, y, c);
                wait_done(k, lat);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
                checks++;
                if (lat !== n_of(k) || {of[k], co[k], sm[k]} !== e) begin
                    failures++;
                    $display("FAIL random[%0d] a=%h b=%h cin=%b: got lat=%0d ovf=%b cout=%b sum=%h want lat=%0d %b %b %h",
                             k, x, y, c, lat, of[k], co[k], sm[k], n_of(k), e[9], e[8], e[7:0]);
                end
                consume(k);
            end
        end
    endtask

    initial begin
        iv = '0; ordy = '0; icin = '0; ia = '0; ib = '0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_hold_back_to_back;
        test_reset_mid_run;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
